// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and default frame
// parameters, common to the transmitter and receiver.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to
// RST_VAL so the synchronised output starts at a known line level.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make both flops sample together, giving a
    // true two-stage shift; blocking here would collapse it into one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises Rx, samples start/data/stop at mid-bit and
// presents each byte on a valid/ready handshake with framing/overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BIDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] IDX_LAST  = BIDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    uart_state_t          next_state;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [BIDX_W-1:0]    bidx;
    logic [DATA_BITS-1:0] shreg;

    logic half_hit;
    logic bit_hit;
    logic cnt_clr;
    logic shift_en;
    logic stop_ok;
    logic stop_bad;
    logic byte_done;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (Rx),
        .q    (rx_s)
    );

    assign half_hit = (cnt == HALF_LAST);
    assign bit_hit  = (cnt == BIT_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (!rx_s) next_state = ST_START;
            ST_START: if (half_hit) next_state = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_hit && (bidx == IDX_LAST)) next_state = ST_STOP;
            ST_STOP:  if (bit_hit) next_state = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Per-state strobes for the datapath and the busy flag
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        cnt_clr  = 1'b1;
        shift_en = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        busy     = (state != ST_IDLE);
        unique case (state)
            ST_START: cnt_clr = half_hit;
            ST_DATA: begin
                cnt_clr  = bit_hit;
                shift_en = bit_hit;
            end
            ST_STOP: begin
                cnt_clr  = bit_hit;
                stop_ok  = bit_hit && rx_s;
                stop_bad = bit_hit && !rx_s;
            end
            default: ;
        endcase
    end

    // Bit timing counter, bit index and LSB-first shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            bidx  <= '0;
            shreg <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state != ST_DATA) begin
                bidx <= '0;
            end else if (shift_en) begin
                bidx <= bidx + BIDX_W'(1);
            end
            if (shift_en) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
        end
    end

    // Output register: a completed byte is delivered one cycle after the stop
    // sample; the shift register is quiet in IDLE so it still holds the byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
        end else begin
            byte_done <= stop_ok;
            frame_err <= stop_bad;
            overrun   <= byte_done && rx_valid && !rx_ready;
            if (byte_done) begin
                rx_valid <= 1'b1;
                if (!rx_valid || rx_ready) begin
                    rx_data <= shreg;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-accurate Rx driver, scoreboard of
// expected bytes, and a negedge monitor comparing every delivered byte.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int start_cyc = 0;

    logic [7:0] exp_q[$];

    int   valid_rises  = 0;
    int   valid_cycles = 0;
    int   fe_cnt       = 0;
    int   ov_cnt       = 0;
    int   busy_cnt     = 0;
    logic prev_valid   = 1'b0;

    uart_rx #(
        .CLKS_PER_BIT(16),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Rx       (rx_line),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: pops an expected byte on every rising rx_valid
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
        end else begin
            if (rx_valid)  valid_cycles <= valid_cycles + 1;
            if (frame_err) fe_cnt       <= fe_cnt + 1;
            if (overrun)   ov_cnt       <= ov_cnt + 1;
            if (busy)      busy_cnt     <= busy_cnt + 1;
            if (rx_valid && !prev_valid) begin
                valid_rises <= valid_rises + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid_data", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                    check_range("latency", cyc - start_cyc, 154, 156);
                end
            end
            prev_valid <= rx_valid;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        start_cyc = cyc;
        rx_line = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (16) @(negedge clk);
        end
        rx_line = stop_bit;
        repeat (16) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rise, base_fe, base_ov, base_vc, base_busy;

        reset    = 1'b1;
        rx_line  = 1'b1;
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;

        // Idle line after reset: nothing may happen
        repeat (200) @(negedge clk);
        check("idle_rises", valid_rises, 0);
        check("idle_frame_err", fe_cnt, 0);
        check("idle_busy_cycles", busy_cnt, 0);
        check_outputs_zero("idle");

        // Single byte, consumer always ready
        rx_ready = 1'b1;
        base_rise = valid_rises;
        base_vc   = valid_cycles;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        check("a5_rises", valid_rises - base_rise, 1);
        check("a5_valid_cycles", valid_cycles - base_vc, 1);

        // Back-to-back bytes with no consumer: second byte overruns
        rx_ready  = 1'b0;
        base_rise = valid_rises;
        base_ov   = ov_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_rises", valid_rises - base_rise, 1);
        check("ovr_pulses", ov_cnt - base_ov, 1);
        check("ovr_valid_held", {31'd0, rx_valid}, 32'd1);
        check("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", {31'd0, rx_valid}, 32'd0);

        // Framing error, then a held-low line, then recovery
        base_rise = valid_rises;
        base_fe   = fe_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40 * 16) @(negedge clk);
        check("brk_frame_err", fe_cnt - base_fe, 1);
        check("brk_rises", valid_rises - base_rise, 0);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("brk_busy_after_release", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        repeat (10) @(negedge clk);
        check("brk_recover_rises", valid_rises - base_rise, 1);
        check("brk_recover_frame_err", fe_cnt - base_fe, 1);

        // Short low glitch on the line
        base_rise = valid_rises;
        base_fe   = fe_cnt;
        base_busy = busy_cnt;
        @(negedge clk);
        rx_line = 1'b0;
        repeat (5) @(negedge clk);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        check_range("glitch_busy_cycles", busy_cnt - base_busy, 1, 10);
        check("glitch_rises", valid_rises - base_rise, 0);
        check("glitch_frame_err", fe_cnt - base_fe, 0);
        check("glitch_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of 0xFF (during bit 4), then a clean 0x0F
        @(negedge clk);
        rx_line = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_line = 1'b1;
            repeat (16) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("midreset");
        reset = 1'b0;
        base_rise = valid_rises;
        base_fe   = fe_cnt;
        repeat (100) @(negedge clk);
        check("midreset_no_partial", valid_rises - base_rise, 0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        repeat (10) @(negedge clk);
        check("midreset_rises", valid_rises - base_rise, 1);
        check("midreset_frame_err", fe_cnt - base_fe, 0);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
